gpi_debounce: RTL and testbench
===============================

// Module: gpi_debounce
// PURPOSE
//  Conditions raw board inputs (switches, buttons) before they reach the demo system's gp_i port.
//  Per-bit flow: multi-flop synchroniser, then a stability-counter debouncer.
//  Outputs are clean levels plus 1-cycle rise/fall strobes in clk_sys.
//  Sits between the pads and ibex_demo_system; consumed as gp_i = db_o.
// PARAMETERS
//  Width          8        number of independent input bits
//  SyncStages     2        synchroniser flops per bit; must be >= 2
//  DebounceCycles 500000   consecutive clk_sys cycles of mismatch before db_o flips
//                          (10 ms @ 50 MHz); must be >= 1
//  CntW (localparam)  $clog2(DebounceCycles+1)   per-bit counter width
// PORTS
//  clk_sys_i   in   1      system clock
//  rst_sys_i   in   1      asynchronous reset, active-high
//  raw_i       in   Width  asynchronous pad inputs, bit order {SW, BTN}
//  db_o        out  Width  debounced level
//  rise_o      out  Width  1-cycle strobe on the cycle db_o bit goes 0->1
//  fall_o      out  Width  1-cycle strobe on the cycle db_o bit goes 1->0
//  changed_o   out  1      |(rise_o | fall_o)
// BEHAVIOUR
//  Clocking and reset
//  - One clock: clk_sys_i. Reset: asynchronous, active-high (rst_sys_i).
//  - While rst_sys_i is asserted: all sync flops, counters, db_o, rise_o, fall_o and changed_o = 0.
//  - Release is synchronous to clk_sys_i. It is the integration's responsibility to deassert reset cleanly.
//  Synchroniser
//  - sync[b] = raw_i[b] delayed by SyncStages flops.
//  - No logic sits between the synchroniser flops.
//  Per-bit debouncer (bits fully independent; no shared state)
//  - Two states per bit, implied by db_o[b]:
//      STABLE:   sync == db.
//      PENDING:  sync != db.
//  - STABLE: cnt <= 0.
//  - PENDING and cnt < DebounceCycles-1: cnt <= cnt+1.
//  - PENDING and cnt == DebounceCycles-1, on the next edge:
//      - db <= sync;
//      - cnt <= 0;
//      - rise/fall strobe asserted for exactly the cycle in which the new db is visible.
//  - Any cycle with sync == db during PENDING clears cnt.
//      - Glitches shorter than DebounceCycles never reach db_o.
//      - No partial-count credit is kept.
//  - Counter never exceeds DebounceCycles-1 and never wraps.
//  Latency
//  - A raw edge held stable changes db_o exactly SyncStages+DebounceCycles edges after the first
//    edge that samples it.
//  - rise_o/fall_o coincide with the db_o change.
//  Boundary cases
//  - DebounceCycles=1: db follows sync with a 1-cycle register delay; every sync change strobes.
//  - Input toggling faster than DebounceCycles: db_o holds, strobes stay 0 indefinitely.
//  - Multiple bits settling in the same cycle: all strobes assert together; changed_o=1 once.
//  - Reset mid-count: the count is discarded. After release, a bit held at 1 produces
//    rise_o SyncStages+DebounceCycles cycles later (power-on switch state is reported as a rise).
//  - rise_o & fall_o is never 1 on the same bit.
//  - Strobes are never asserted for 2 consecutive cycles on one bit.
// TESTING  (Width=8, SyncStages=2, DebounceCycles=4 unless noted)
//  1. Reset, raw_i=8'h00 for 20 cycles
//     -> db_o=0, rise_o=fall_o=0, changed_o=0 throughout.
//  2. raw_i[0] 0->1, held
//     -> db_o[0]=1 and rise_o=8'h01 exactly 6 cycles later for 1 cycle; changed_o=1 that cycle only.
//  3. raw_i[3] pulsed high for 3 cycles, then low
//     -> db_o stays 8'h00, no strobes.
//     Repeat with a 4-cycle pulse -> rise on bit 3, then fall 4 cycles later.
//  4. raw_i 8'h00->8'hA5 in one cycle
//     -> 6 cycles later db_o=8'hA5, rise_o=8'hA5, changed_o=1 for 1 cycle.
//  5. raw_i[7] high; assert rst_sys_i at cycle 3 of the count, release after 2 cycles
//     -> all outputs 0 during reset; rise_o[7] 6 cycles after release.
//  6. DebounceCycles=1: raw_i[1] toggles every 2 cycles
//     -> db_o[1] tracks it delayed 3 cycles; alternating rise/fall strobes, never both.

Source files
------------

// File: rtl/gpi_debounce.sv
// Pad-input conditioner: per-bit synchroniser feeding a stability-counter debouncer,
// producing clean levels plus single-cycle rise/fall strobes in the clk_sys domain.

module gpi_debounce_lane #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 500000,
  parameter int CntW           = $clog2(DebounceCycles + 1)
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  db_q, db_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  // Plain flop chain: nothing may sit between stages or metastability margin is lost.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) sync_q <= '0;
    else           sync_q <= {sync_q[SyncStages-2:0], raw_i};
  end

  assign sync = sync_q[SyncStages-1];

  // Any agreeing cycle drops the count to zero, so only an unbroken run flips db.
  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync != db_q) begin
      if (cnt_q == CntMax) begin
        db_d   = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

module gpi_debounce #(
  parameter int Width          = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 500000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] db_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);

  for (genvar g = 0; g < Width; g++) begin : g_lane
    gpi_debounce_lane #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .CntW          (CntW)
    ) u_lane (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .raw_i    (raw_i[g]),
      .db_o     (db_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g])
    );
  end

  assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: table-driven vectors through a scoreboard queue (DebounceCycles=4),
// plus hand sequences for reset mid-count and a DebounceCycles=1 instance.

module tb_gpi_debounce;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw, raw1;
  logic [7:0] db, rise, fall, db1, rise1, fall1;
  logic       changed, changed1;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  gpi_debounce #(.Width(8), .SyncStages(2), .DebounceCycles(4)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .raw_i(raw),
    .db_o(db), .rise_o(rise), .fall_o(fall), .changed_o(changed)
  );

  gpi_debounce #(.Width(8), .SyncStages(2), .DebounceCycles(1)) dut1 (
    .clk_sys_i(clk), .rst_sys_i(rst), .raw_i(raw1),
    .db_o(db1), .rise_o(rise1), .fall_o(fall1), .changed_o(changed1)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic v(input logic [7:0] r, input logic [7:0] d, input logic [7:0] ri,
                   input logic [7:0] fa, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, d, ri, fa});
  endtask

  task automatic chk_main(input vec_t e, input int idx);
    chk("db",      idx, {24'h0, db},      {24'h0, e.db});
    chk("rise",    idx, {24'h0, rise},    {24'h0, e.rise});
    chk("fall",    idx, {24'h0, fall},    {24'h0, e.fall});
    chk("changed", idx, {31'h0, changed}, {31'h0, |(e.rise | e.fall)});
    chk("rise_and_fall", idx, {24'h0, rise & fall}, 32'h0);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare once the edge has produced output.
  task automatic step(input vec_t e, input int idx);
    vec_t x;
    @(negedge clk);
    raw = e.raw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk_main(x, idx);
  endtask

  task automatic run(input logic [7:0] r, input logic [7:0] d, input logic [7:0] ri,
                     input logic [7:0] fa, input int n, input int base);
    for (int i = 0; i < n; i++) step('{r, d, ri, fa}, base + i);
  endtask

  task automatic chk_all_zero(input string nm, input int idx);
    chk(nm, idx, {db, rise, fall, 7'h0, changed}, 32'h0);
    chk({nm, "_dc1"}, idx, {db1, rise1, fall1, 7'h0, changed1}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t x;
    logic [7:0] prev;
    logic [7:0] r;

    // Test 1: idle after reset
    v(8'h00, 8'h00, 8'h00, 8'h00, 20);
    // Test 2: bit 0 rises, later falls
    v(8'h01, 8'h00, 8'h00, 8'h00, 5);
    v(8'h01, 8'h01, 8'h01, 8'h00, 1);
    v(8'h01, 8'h01, 8'h00, 8'h00, 3);
    v(8'h00, 8'h01, 8'h00, 8'h00, 5);
    v(8'h00, 8'h00, 8'h00, 8'h01, 1);
    v(8'h00, 8'h00, 8'h00, 8'h00, 3);
    // Test 3a: 3-cycle glitch is filtered
    v(8'h08, 8'h00, 8'h00, 8'h00, 3);
    v(8'h00, 8'h00, 8'h00, 8'h00, 10);
    // Test 3b: 4-cycle pulse passes, then falls 4 cycles later
    v(8'h08, 8'h00, 8'h00, 8'h00, 4);
    v(8'h00, 8'h00, 8'h00, 8'h00, 1);
    v(8'h00, 8'h08, 8'h08, 8'h00, 1);
    v(8'h00, 8'h08, 8'h00, 8'h00, 3);
    v(8'h00, 8'h00, 8'h00, 8'h08, 1);
    v(8'h00, 8'h00, 8'h00, 8'h00, 3);
    // Fast toggling on bit 2 never settles
    for (int i = 0; i < 6; i++) begin
      v(8'h04, 8'h00, 8'h00, 8'h00, 2);
      v(8'h00, 8'h00, 8'h00, 8'h00, 2);
    end
    v(8'h00, 8'h00, 8'h00, 8'h00, 4);
    // Test 4: several bits settle together
    v(8'hA5, 8'h00, 8'h00, 8'h00, 5);
    v(8'hA5, 8'hA5, 8'hA5, 8'h00, 1);
    v(8'hA5, 8'hA5, 8'h00, 8'h00, 3);
    v(8'h00, 8'hA5, 8'h00, 8'h00, 5);
    v(8'h00, 8'h00, 8'h00, 8'hA5, 1);
    v(8'h00, 8'h00, 8'h00, 8'h00, 3);

    rst  = 1'b1;
    raw  = 8'h00;
    raw1 = 8'h00;
    #1;
    chk_all_zero("reset_async", 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all_zero("reset_hold", i);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Test 5: reset in the middle of a count on bit 7
    run(8'h80, 8'h00, 8'h00, 8'h00, 4, 500);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst_async", 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_all_zero("midrst_hold", i);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_db",   k, {24'h0, db},   (k >= 5) ? 32'h80 : 32'h0);
      chk("post_rst_rise", k, {24'h0, rise}, (k == 5) ? 32'h80 : 32'h0);
      chk("post_rst_fall", k, {24'h0, fall}, 32'h0);
    end
    run(8'h00, 8'h80, 8'h00, 8'h00, 5, 600);
    run(8'h00, 8'h00, 8'h00, 8'h80, 1, 605);
    run(8'h00, 8'h00, 8'h00, 8'h00, 2, 606);

    // Test 6: DebounceCycles=1, bit 1 toggles every 2 cycles; db lags raw by 3 edges
    sb.delete();
    sb.push_back('{8'h00, 8'h00, 8'h00, 8'h00});
    sb.push_back('{8'h00, 8'h00, 8'h00, 8'h00});
    prev = 8'h00;
    for (int t = 0; t < 20; t++) begin
      r = (t < 16 && ((t / 2) % 2) == 1) ? 8'h02 : 8'h00;
      @(negedge clk);
      raw1 = r;
      sb.push_back('{r, r, r & ~prev, prev & ~r});
      prev = r;
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("dc1_db",      t, {24'h0, db1},      {24'h0, x.db});
      chk("dc1_rise",    t, {24'h0, rise1},    {24'h0, x.rise});
      chk("dc1_fall",    t, {24'h0, fall1},    {24'h0, x.fall});
      chk("dc1_changed", t, {31'h0, changed1}, {31'h0, |(x.rise | x.fall)});
      chk("dc1_rise_and_fall", t, {24'h0, rise1 & fall1}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
